// File: rtl/mem_pkg.sv
// Shared types for the memory access unit: access sizes, FSM states, read-latency bounds
// and the alignment rule.
package mem_pkg;

  typedef enum logic [1:0] {
    SizeB = 2'd0,
    SizeH = 2'd1,
    SizeW = 2'd2,
    SizeD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } mau_state_e;

  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 4;

  // An access is aligned when the address is a multiple of its size in bytes.
  function automatic logic is_misaligned(logic [2:0] addr_lo, mem_size_e size);
    logic mis;
    case (size)
      SizeB:   mis = 1'b0;
      SizeH:   mis = addr_lo[0];
      SizeW:   mis = |addr_lo[1:0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: places store data and byte enables onto the 64-bit bus, and extracts
// and sign/zero-extends load data from it.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  input  logic [63:0] st_data_in,
  input  logic [63:0] ld_data_in,
  output logic [63:0] st_data,
  output logic [7:0]  st_mask,
  output logic [63:0] ld_data
);

  logic [5:0]  bit_shift;
  logic [63:0] st_trunc;
  logic [63:0] ld_shifted;
  logic [7:0]  byte_mask;
  logic        ext_signed;

  assign bit_shift  = {addr_lo, 3'b000};
  assign ld_shifted = ld_data_in >> bit_shift;
  assign ext_signed = ~is_unsigned;

  always_comb begin
    st_trunc  = st_data_in;
    byte_mask = 8'hFF;
    ld_data   = ld_shifted;
    case (size)
      SizeB: begin
        st_trunc  = {56'd0, st_data_in[7:0]};
        byte_mask = 8'h01;
        ld_data   = {{56{ext_signed & ld_shifted[7]}}, ld_shifted[7:0]};
      end
      SizeH: begin
        st_trunc  = {48'd0, st_data_in[15:0]};
        byte_mask = 8'h03;
        ld_data   = {{48{ext_signed & ld_shifted[15]}}, ld_shifted[15:0]};
      end
      SizeW: begin
        st_trunc  = {32'd0, st_data_in[31:0]};
        byte_mask = 8'h0F;
        ld_data   = {{32{ext_signed & ld_shifted[31]}}, ld_shifted[31:0]};
      end
      default: ;
    endcase
  end

  assign st_data = st_trunc << bit_shift;
  assign st_mask = byte_mask << addr_lo;

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: accepts one pipeline request, issues one strobe to a
// fixed-latency memory, and returns an extended load result or a misalignment error.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata
);

  localparam logic [1:0] CntInit = 2'(RD_LAT - 1);

  mau_state_e  state_q, state_d;
  logic        wen_q, uns_q;
  logic [63:0] addr_q, wdata_q;
  mem_size_e   size_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [63:0] mem_addr_q, mem_wdata_q;
  logic        accept;
  logic [63:0] st_data, ld_data;
  logic [7:0]  st_mask;

  mem_lane_align u_lane_align (
    .addr_lo     (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .st_data_in  (wdata_q),
    .ld_data_in  (mem_rdata),
    .st_data     (st_data),
    .st_mask     (st_mask),
    .ld_data     (ld_data)
  );

  always_comb begin
    accept       = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept       = 1'b1;
          resp_rdata_d = '0;
          if (is_misaligned(req_addr[2:0], mem_size_e'(req_size))) begin
            resp_err_d = 1'b1;
            state_d    = StResp;
          end else begin
            resp_err_d = 1'b0;
            state_d    = StIssue;
          end
        end
      end
      StIssue: begin
        if (wen_q) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          resp_rdata_d = ld_data;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StResp: begin
        // Completion cycle never also accepts: req_ready only rises once back in idle.
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wen_q        <= 1'b0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= SizeB;
      cnt_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr;
      mem_wdata_q  <= mem_wdata;
      if (accept) begin
        wen_q   <= req_wen;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= mem_size_e'(req_size);
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Bus address/data hold the last issued values outside the strobe cycle.
  assign mem_ce    = (state_q == StIssue);
  assign mem_we    = mem_ce & wen_q;
  assign mem_wmask = mem_we ? st_mask : 8'h00;
  assign mem_addr  = mem_ce ? {addr_q[63:3], 3'b000} : mem_addr_q;
  assign mem_wdata = mem_we ? st_data : mem_wdata_q;

endmodule
